lsu_bus_bridge: RTL

Load/store bridge between the MEM stage of the RV32 pipeline and a variable-latency data bus with request/grant and read-valid handshakes. It replaces the single-cycle `mem_addr`/`mem_wr_data`/`mem_rd_data` path with a bus interface that can take any number of cycles. It holds the pipeline with `stall_o` until the access completes, and performs byte-lane steering, byte-enable generation, load sign/zero extension and misalignment detection.

---
 rtl/lsu_bus_bridge.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_bus_bridge.sv
// rtl/lsu_bus_bridge.sv - MEM-stage load/store bridge onto a request/grant, read-valid data bus
// Define LSU_BUS_TIMEOUT_EN to abort accesses that exceed TIMEOUT_CYC bus cycles.
module lsu_bus_bridge #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid_i,
  input  logic              req_we_i,
  input  logic [2:0]        req_lsu_op_i,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              stall_o,
  output logic [31:0]       rdata_o,
  output logic              rdata_valid_o,
  output logic              misaligned_o,
  output logic              bus_err_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [31:0]       bus_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        op_q, op_d;
  logic [1:0]        off_q, off_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              misaligned;
  logic [3:0]        be_new;
  logic [31:0]       wdata_new;
  logic [31:0]       lane;
  logic [31:0]       load_ext;

`ifdef LSU_BUS_TIMEOUT_EN
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              timeout_hit;
`else
  logic              unused_timeout;
  assign unused_timeout = |8'(TIMEOUT_CYC);
`endif

  always_comb begin
    misaligned = 1'b0;
    be_new     = 4'b1111;
    wdata_new  = req_wdata_i;
    case (req_lsu_op_i[1:0])
      2'b00: begin
        be_new    = 4'b0001 << req_addr_i[1:0];
        wdata_new = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        misaligned = req_addr_i[0];
        be_new     = 4'b0011 << req_addr_i[1:0];
        wdata_new  = {2{req_wdata_i[15:0]}};
      end
      default: misaligned = |req_addr_i[1:0];
    endcase
  end

  assign lane = bus_rdata_i >> {off_q, 3'b000};

  always_comb begin
    load_ext = lane;
    case (op_q)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {24'd0, lane[7:0]};
      3'b101:  load_ext = {16'd0, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    op_d    = op_q;
    off_d   = off_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef LSU_BUS_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
    timeout_hit = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid_i && !misaligned) begin
          state_d = REQ;
          we_d    = req_we_i;
          op_d    = req_lsu_op_i;
          off_d   = req_addr_i[1:0];
          addr_d  = {req_addr_i[ADDR_W-1:2], 2'b00};
          be_d    = be_new;
          wdata_d = wdata_new;
        end
      end
      REQ: begin
        if (bus_gnt_i) state_d = we_q ? DONE : WAIT_R;
      end
      WAIT_R: begin
        if (bus_rvalid_i) begin
          rdata_d = load_ext;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef LSU_BUS_TIMEOUT_EN
    // An access that completes on the limit cycle still wins over the timeout.
    if (state_q == IDLE) begin
      cnt_d = 8'd0;
      err_d = 1'b0;
    end else if (state_q == REQ || state_q == WAIT_R) begin
      cnt_d       = cnt_q + 8'd1;
      timeout_hit = (cnt_d == 8'(TIMEOUT_CYC))
                    && !(state_q == REQ && bus_gnt_i && we_q)
                    && !(state_q == WAIT_R && bus_rvalid_i);
      if (timeout_hit) begin
        state_d = DONE;
        err_d   = 1'b1;
        rdata_d = we_q ? rdata_q : 32'd0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      op_q    <= 3'd0;
      off_q   <= 2'd0;
      addr_q  <= '0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
`ifdef LSU_BUS_TIMEOUT_EN
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      op_q    <= op_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef LSU_BUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign stall_o       = req_valid_i & (state_q != DONE) & ~misaligned;
  assign misaligned_o  = (state_q == IDLE) & req_valid_i & misaligned;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = (state_q == DONE) & ~we_q;
  assign bus_req_o     = (state_q == REQ);
  assign bus_we_o      = bus_req_o & we_q;
  assign bus_addr_o    = bus_req_o ? addr_q : '0;
  assign bus_be_o      = bus_req_o ? be_q : 4'd0;
  assign bus_wdata_o   = bus_req_o ? wdata_q : 32'd0;
`ifdef LSU_BUS_TIMEOUT_EN
  assign bus_err_o     = (state_q == DONE) & err_q;
`else
  assign bus_err_o     = 1'b0;
`endif

endmodule
